// File: rtl/uart_tx_framer_pkg.sv
// rtl/uart_tx_framer_pkg.sv - shared UART framing types: state encoding and parity helper
package uart_tx_framer_pkg;

    localparam int STATE_W = 3;

    // Encoding is shared with the receive-side deframer, so the values are pinned.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic PARITY_MODE_ODD = 1'b1;

    // Parity bit from the XOR-reduction of the word: even parity sends the reduction as-is.
    function automatic logic parity_bit(input logic data_xor, input logic odd_mode);
        return (odd_mode == PARITY_MODE_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_framer_bit_timer.sv
// rtl/uart_tx_framer_bit_timer.sv - enable-gated mod-OVERSAMPLE counter marking the end of each bit
module uart_tx_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] count;

    assign bit_end = enable & (count == LAST);

    // Count oversample ticks; wrap on the last tick of a bit, hold when no tick arrives.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start, LSB-first data, optional parity, stop bits
module uart_tx_framer
    import uart_tx_framer_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    state_t                state;
    state_t                next_state;
    logic [DATA_BITS-1:0]  shift_q;
    logic [DATA_BITS-1:0]  shift_d;
    logic [BIT_W-1:0]      bit_idx_q;
    logic [BIT_W-1:0]      bit_idx_d;
    logic                  stop_idx_q;
    logic                  stop_idx_d;
    logic                  parity_q;
    logic                  parity_d;
    logic                  tx_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  accept;
    logic                  timer_en;
    logic                  bit_end;

    assign tx_ready = (state == ST_IDLE);
    assign accept   = tx_valid & tx_ready;
    // Ticks seen while idle must not advance the timer, so a new frame starts bit-aligned.
    assign timer_en = baud_tick & (state != ST_IDLE);

    uart_tx_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (timer_en),
        .clear  (accept),
        .bit_end(bit_end)
    );

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: advance one field of the frame at each bit end.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_START;
            ST_START:  if (bit_end) next_state = ST_DATA;
            ST_DATA:   if (bit_end && bit_idx_q == LAST_BIT)
                           next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) next_state = ST_STOP;
            ST_STOP:   if (bit_end && stop_idx_q == LAST_STOP) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Datapath next values: latch word and parity on accept, shift and count at bit ends.
    always_comb begin
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;
        if (accept) begin
            shift_d    = tx_data;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            parity_d   = parity_bit(^tx_data, PARITY_ODD != 0);
        end else if (bit_end) begin
            if (state == ST_DATA) begin
                shift_d   = shift_q >> 1;
                bit_idx_d = (bit_idx_q == LAST_BIT) ? '0 : bit_idx_q + 1'b1;
            end
            if (state == ST_STOP) begin
                stop_idx_d = stop_idx_q + 1'b1;
            end
        end
    end

    // Output decode from the upcoming state so the registered line changes with the state.
    always_comb begin
        tx_d = 1'b1;
        case (next_state)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (next_state != ST_IDLE);
        done_d = (state != ST_IDLE) && (next_state == ST_IDLE);
    end

    // Registered outputs and datapath; the line idles high.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
        end else begin
            tx         <= tx_d;
            tx_busy    <= busy_d;
            tx_done    <= done_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer in 8N1, 8E2 and 8O1 builds
module tb_uart_tx_framer;

    localparam int OS = 16;
    localparam int DB = 8;
    localparam int NI = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          baud_tick = 1'b0;
    logic [NI-1:0] valid_v = '0;
    logic [DB-1:0] data_v [NI];
    wire  [NI-1:0] ready_v;
    wire  [NI-1:0] tx_v;
    wire  [NI-1:0] busy_v;
    wire  [NI-1:0] done_v;

    int checks = 0;
    int errors = 0;
    int div = 0;
    bit stall = 1'b0;

    bit in_frame [NI];
    int n_tick   [NI];
    int total    [NI];
    bit lvl      [NI][16];
    bit exp_done [NI];
    int acc_cnt  [NI];
    int obs_done [NI];
    int busy_ticks [NI];

    uart_tx_framer #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_8n1 (
        .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_valid(valid_v[0]), .tx_data(data_v[0]),
        .tx_ready(ready_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx_framer #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) dut_8e2 (
        .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_valid(valid_v[1]), .tx_data(data_v[1]),
        .tx_ready(ready_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx_framer #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_8o1 (
        .clock(clock), .reset(reset), .baud_tick(baud_tick), .tx_valid(valid_v[2]), .tx_data(data_v[2]),
        .tx_ready(ready_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic int pe_of(int i);  return (i != 0) ? 1 : 0; endfunction
    function automatic bit odd_of(int i); return (i == 2); endfunction
    function automatic int sb_of(int i);  return (i == 1) ? 2 : 1; endfunction
    function automatic int frame_ticks(int i); return OS * (1 + DB + pe_of(i) + sb_of(i)); endfunction

    function automatic bit any_busy();
        bit b = 1'b0;
        for (int i = 0; i < NI; i++) b |= in_frame[i];
        return b;
    endfunction

    // Frame as a list of bit levels: start, data LSB first, parity, stops.
    task automatic load_frame(input int i, input logic [DB-1:0] w);
        int k = 0;
        lvl[i][k] = 1'b0; k++;
        for (int b = 0; b < DB; b++) begin lvl[i][k] = w[b]; k++; end
        if (pe_of(i) != 0) begin
            int ones = 0;
            for (int b = 0; b < DB; b++) ones += int'(w[b]);
            lvl[i][k] = odd_of(i) ? ((ones % 2) == 0) : ((ones % 2) == 1); k++;
        end
        for (int s = 0; s < sb_of(i); s++) begin lvl[i][k] = 1'b1; k++; end
        total[i] = k * OS;
    endtask

    function automatic logic [3:0] exp_vec(int i);
        logic t = in_frame[i] ? lvl[i][n_tick[i] / OS] : 1'b1;
        return {t, logic'(in_frame[i]), logic'(exp_done[i]), logic'(!in_frame[i])};
    endfunction

    // One clock: model advances on the edge, DUT is sampled at the falling edge.
    task automatic step();
        for (int i = 0; i < NI; i++) if (busy_v[i] && baud_tick) busy_ticks[i]++;
        @(posedge clock);
        for (int i = 0; i < NI; i++) begin
            exp_done[i] = 1'b0;
            if (reset) begin
                in_frame[i] = 1'b0;
            end else if (in_frame[i]) begin
                if (baud_tick) n_tick[i]++;
                if (n_tick[i] == total[i]) begin
                    in_frame[i] = 1'b0;
                    exp_done[i] = 1'b1;
                end
            end else if (valid_v[i]) begin
                load_frame(i, data_v[i]);
                in_frame[i] = 1'b1;
                n_tick[i]   = 0;
                acc_cnt[i]++;
            end
        end
        @(negedge clock);
        for (int i = 0; i < NI; i++) if (done_v[i]) obs_done[i]++;
        div = (div + 1) % 4;
        baud_tick = !stall && (div == 0);
    endtask

    task automatic test_reset();
        logic [3:0] got;
        reset = 1'b1;
        valid_v = '1;
        for (int i = 0; i < NI; i++) data_v[i] = 8'($urandom);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin reset = 1'b0; valid_v = '0; end
            step();
            for (int i = 0; i < NI; i++) begin
                got = {tx_v[i], busy_v[i], done_v[i], ready_v[i]};
                checks++;
                if (got !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL reset inst%0d cyc%0d: tx/busy/done/ready got %b want %b", i, c, got, exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_frame(input logic [DB-1:0] w, input string name);
        logic [3:0] got;
        int bt0 [NI];
        int od0 [NI];
        for (int i = 0; i < NI; i++) begin bt0[i] = busy_ticks[i]; od0[i] = obs_done[i]; data_v[i] = w; end
        valid_v = '1;
        step();
        valid_v = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NI; i++) begin
                got = {tx_v[i], busy_v[i], done_v[i], ready_v[i]};
                checks++;
                if (got !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL %s inst%0d cyc%0d: tx/busy/done/ready got %b want %b", name, i, c, got, exp_vec(i));
                end
            end
            if (!any_busy()) break;
            step();
        end
        checks++;
        if (any_busy()) begin errors++; $display("FAIL %s timeout: frame still running want idle", name); end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (busy_ticks[i] - bt0[i] != frame_ticks(i)) begin
                errors++;
                $display("FAIL %s_len inst%0d: busy ticks %0d want %0d", name, i, busy_ticks[i] - bt0[i], frame_ticks(i));
            end
            checks++;
            if (obs_done[i] - od0[i] != 1) begin
                errors++;
                $display("FAIL %s_done inst%0d: done pulses %0d want 1", name, i, obs_done[i] - od0[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        int acc0 [NI];
        int od0 [NI];
        int done_cyc = -1;
        int rise_cyc = -1;
        bit all2;
        for (int i = 0; i < NI; i++) begin acc0[i] = acc_cnt[i]; od0[i] = obs_done[i]; data_v[i] = 8'h3C; end
        valid_v = '1;
        for (int c = 0; c < 6000; c++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                got = {tx_v[i], busy_v[i], done_v[i], ready_v[i]};
                checks++;
                if (got !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL b2b inst%0d cyc%0d: tx/busy/done/ready got %b want %b", i, c, got, exp_vec(i));
                end
                if (acc_cnt[i] - acc0[i] >= 1) data_v[i] = 8'hC3;
                if (acc_cnt[i] - acc0[i] >= 2) valid_v[i] = 1'b0;
            end
            if (done_v[0] && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && rise_cyc < 0 && busy_v[0]) rise_cyc = c;
            all2 = 1'b1;
            for (int i = 0; i < NI; i++) if (acc_cnt[i] - acc0[i] < 2) all2 = 1'b0;
            if (all2 && !any_busy()) break;
        end
        valid_v = '0;
        checks++;
        if (done_cyc < 0 || rise_cyc - done_cyc != 1) begin
            errors++;
            $display("FAIL b2b_gap: done at cyc %0d restart at cyc %0d want restart 1 cycle after done", done_cyc, rise_cyc);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs_done[i] - od0[i] != 2) begin
                errors++;
                $display("FAIL b2b_frames inst%0d: done pulses %0d want 2", i, obs_done[i] - od0[i]);
            end
        end
    endtask

    task automatic test_busy_pulses();
        logic [3:0] got;
        int od0 [NI];
        for (int i = 0; i < NI; i++) begin od0[i] = obs_done[i]; data_v[i] = 8'($urandom); end
        valid_v = '1;
        step();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NI; i++) begin
                got = {tx_v[i], busy_v[i], done_v[i], ready_v[i]};
                checks++;
                if (got !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL busy_pulse inst%0d cyc%0d: tx/busy/done/ready got %b want %b", i, c, got, exp_vec(i));
                end
                valid_v[i] = in_frame[i] ? 1'($urandom) : 1'b0;
                data_v[i]  = 8'($urandom);
            end
            if (!any_busy()) break;
            step();
        end
        valid_v = '0;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs_done[i] - od0[i] != 1) begin
                errors++;
                $display("FAIL busy_pulse_frames inst%0d: done pulses %0d want 1", i, obs_done[i] - od0[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] got;
        int stalled = 0;
        for (int i = 0; i < NI; i++) data_v[i] = 8'h96;
        valid_v = '1;
        step();
        valid_v = '0;
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < NI; i++) begin
                got = {tx_v[i], busy_v[i], done_v[i], ready_v[i]};
                checks++;
                if (got !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL stall inst%0d cyc%0d: tx/busy/done/ready got %b want %b", i, c, got, exp_vec(i));
                end
            end
            if (!any_busy()) break;
            if (stalled == 0 && n_tick[0] >= 3 * OS + 5) begin stall = 1'b1; baud_tick = 1'b0; end
            if (stall) begin
                stalled++;
                if (stalled > 50) stall = 1'b0;
            end
            step();
        end
        checks++;
        if (stalled <= 50 || any_busy()) begin
            errors++;
            $display("FAIL stall_run: stalled cycles %0d want 51, busy %0d want 0", stalled, any_busy());
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] got;
        int od0 [NI];
        for (int i = 0; i < NI; i++) data_v[i] = 8'hF0;
        valid_v = '1;
        step();
        valid_v = '0;
        for (int c = 0; c < 1000 && n_tick[0] < 4 * OS + 3; c++) step();
        for (int i = 0; i < NI; i++) od0[i] = obs_done[i];
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NI; i++) begin
                got = {tx_v[i], busy_v[i], done_v[i], ready_v[i]};
                checks++;
                if (got !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL mid_reset inst%0d cyc%0d: tx/busy/done/ready got %b want %b", i, c, got, exp_vec(i));
                end
            end
            step();
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs_done[i] != od0[i]) begin
                errors++;
                $display("FAIL mid_reset_done inst%0d: done pulses %0d want 0", i, obs_done[i] - od0[i]);
            end
        end
        test_frame(8'h55, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            data_v[i] = '0; in_frame[i] = 1'b0; n_tick[i] = 0; total[i] = 0; exp_done[i] = 1'b0;
            acc_cnt[i] = 0; obs_done[i] = 0; busy_ticks[i] = 0;
        end
        test_reset();
        test_frame(8'hA5, "frame_a5");
        test_frame(8'h07, "frame_07");
        test_frame(8'($urandom), "frame_rand");
        test_back_to_back();
        test_busy_pulses();
        test_stall();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
